// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit byte channel among operate, target and script requesters.
// One byte is latched per grant and held until tx_done, then a fixed idle gap is enforced.
module uart_tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       script_run,
  input  logic       op_valid,
  input  logic [7:0] op_bits,
  output logic       op_ack,
  input  logic       tg_valid,
  input  logic [7:0] tg_bits,
  output logic       tg_ack,
  input  logic       sc_valid,
  input  logic [7:0] sc_bits,
  output logic       sc_ack,
  output logic [7:0] tx_bits,
  input  logic       tx_done,
  output logic       busy,
  output logic [7:0] last_byte,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic             RR_OP    = 1'b0;
  localparam logic             RR_TG    = 1'b1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rr_ptr_r;
  logic [7:0]       tx_bits_r;
  logic [7:0]       last_byte_r;
  logic             op_ack_r;
  logic             tg_ack_r;
  logic             sc_ack_r;
  logic             busy_r;
  logic             timeout_err_r;

  logic             grant_op_s;
  logic             grant_tg_s;
  logic             grant_sc_s;
  logic             grant_any_s;
  logic [7:0]       grant_bits_s;

  // Winner selection; only meaningful in IDLE, script_run gates which sources are eligible
  always_comb begin
    grant_op_s   = 1'b0;
    grant_tg_s   = 1'b0;
    grant_sc_s   = 1'b0;
    grant_bits_s = 8'h00;
    if (state_r != ST_IDLE) begin
      grant_sc_s = 1'b0;
    end else if (script_run) begin
      grant_sc_s = sc_valid;
    end else if (op_valid && tg_valid) begin
      if (rr_ptr_r == RR_OP) begin
        grant_op_s = 1'b1;
      end else begin
        grant_tg_s = 1'b1;
      end
    end else begin
      grant_op_s = op_valid;
      grant_tg_s = tg_valid;
    end
    if (grant_sc_s) begin
      grant_bits_s = sc_bits;
    end else if (grant_op_s) begin
      grant_bits_s = op_bits;
    end else if (grant_tg_s) begin
      grant_bits_s = tg_bits;
    end else begin
      grant_bits_s = 8'h00;
    end
  end

  assign grant_any_s = grant_op_s | grant_tg_s | grant_sc_s;

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      rr_ptr_r      <= RR_OP;
      tx_bits_r     <= 8'h00;
      last_byte_r   <= 8'h00;
      op_ack_r      <= 1'b0;
      tg_ack_r      <= 1'b0;
      sc_ack_r      <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      op_ack_r <= 1'b0;
      tg_ack_r <= 1'b0;
      sc_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_any_s) begin
            tx_bits_r <= grant_bits_s;
            op_ack_r  <= grant_op_s;
            tg_ack_r  <= grant_tg_s;
            sc_ack_r  <= grant_sc_s;
            cnt_r     <= '0;
            busy_r    <= 1'b1;
            state_r   <= ST_SEND;
            // Script grants leave the op/tg rotation untouched
            if (grant_op_s) begin
              rr_ptr_r <= RR_TG;
            end else if (grant_tg_s) begin
              rr_ptr_r <= RR_OP;
            end else begin
              rr_ptr_r <= rr_ptr_r;
            end
          end else begin
            tx_bits_r <= 8'h00;
          end
        end
        ST_SEND: begin
          // tx_done is checked first so a coincident timeout still counts as success
          if (tx_done) begin
            last_byte_r <= tx_bits_r;
            tx_bits_r   <= 8'h00;
            cnt_r       <= '0;
            state_r     <= ST_GAP;
          end else if (cnt_r == TO_LAST) begin
            timeout_err_r <= 1'b1;
            tx_bits_r     <= 8'h00;
            cnt_r         <= '0;
            state_r       <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= '0;
          tx_bits_r <= 8'h00;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign op_ack      = op_ack_r;
  assign tg_ack      = tg_ack_r;
  assign sc_ack      = sc_ack_r;
  assign tx_bits     = tx_bits_r;
  assign busy        = busy_r;
  assign last_byte   = last_byte_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with hand-computed expectations.
module tb_uart_tx_scheduler;

  logic       clock;
  logic       reset;
  logic       script_run;
  logic       op_valid;
  logic [7:0] op_bits;
  logic       op_ack;
  logic       tg_valid;
  logic [7:0] tg_bits;
  logic       tg_ack;
  logic       sc_valid;
  logic [7:0] sc_bits;
  logic       sc_ack;
  logic [7:0] tx_bits;
  logic       tx_done;
  logic       busy;
  logic [7:0] last_byte;
  logic       timeout_err;

  int n_total;
  int n_bad;

  uart_tx_scheduler #(
    .GAP_CYCLES(16),
    .TIMEOUT_CYCLES(4096),
    .CNT_W(13)
  ) dut (
    .clock(clock),
    .reset(reset),
    .script_run(script_run),
    .op_valid(op_valid),
    .op_bits(op_bits),
    .op_ack(op_ack),
    .tg_valid(tg_valid),
    .tg_bits(tg_bits),
    .tg_ack(tg_ack),
    .sc_valid(sc_valid),
    .sc_bits(sc_bits),
    .sc_ack(sc_ack),
    .tx_bits(tx_bits),
    .tx_done(tx_done),
    .busy(busy),
    .last_byte(last_byte),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  logic [7:0] rr_exp_bits [4];
  logic       rr_exp_op   [4];

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset      = 1'b0;
    script_run = 1'b0;
    op_valid   = 1'b0;
    op_bits    = 8'h00;
    tg_valid   = 1'b0;
    tg_bits    = 8'h00;
    sc_valid   = 1'b0;
    sc_bits    = 8'h00;
    tx_done    = 1'b0;
    #2;
    check_eq("rst_tx_bits", {24'd0, tx_bits}, 32'h00);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_last_byte", {24'd0, last_byte}, 32'h00);
    check_eq("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check_eq("rst_acks", {29'd0, op_ack, tg_ack, sc_ack}, 32'd0);
    do_reset();

    // Test 1: single operate byte, gap length
    op_valid = 1'b1;
    op_bits  = 8'h21;
    tick();
    check_eq("t1_op_ack", {31'd0, op_ack}, 32'd1);
    check_eq("t1_tx_bits", {24'd0, tx_bits}, 32'h21);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    op_valid = 1'b0;
    tick();
    check_eq("t1_ack_pulse", {31'd0, op_ack}, 32'd0);
    check_eq("t1_tx_hold", {24'd0, tx_bits}, 32'h21);
    repeat (48) tick();
    pulse_done();
    check_eq("t1_last_byte", {24'd0, last_byte}, 32'h21);
    check_eq("t1_gap_tx", {24'd0, tx_bits}, 32'h00);
    repeat (15) tick();
    check_eq("t1_gap_busy", {31'd0, busy}, 32'd1);
    check_eq("t1_gap_tx_end", {24'd0, tx_bits}, 32'h00);
    tick();
    check_eq("t1_busy_fall", {31'd0, busy}, 32'd0);

    // Test 2: round robin between op and tg
    do_reset();
    rr_exp_bits[0] = 8'h11; rr_exp_op[0] = 1'b1;
    rr_exp_bits[1] = 8'h32; rr_exp_op[1] = 1'b0;
    rr_exp_bits[2] = 8'h11; rr_exp_op[2] = 1'b1;
    rr_exp_bits[3] = 8'h32; rr_exp_op[3] = 1'b0;
    op_valid = 1'b1; op_bits = 8'h11;
    tg_valid = 1'b1; tg_bits = 8'h32;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t2_tx_bits_%0d", k), {24'd0, tx_bits}, {24'd0, rr_exp_bits[k]});
      check_eq($sformatf("t2_acks_%0d", k), {30'd0, op_ack, tg_ack}, {30'd0, rr_exp_op[k], ~rr_exp_op[k]});
      repeat (9) tick();
      check_eq($sformatf("t2_no_ack_send_%0d", k), {30'd0, op_ack, tg_ack}, 32'd0);
      pulse_done();
      check_eq($sformatf("t2_last_%0d", k), {24'd0, last_byte}, {24'd0, rr_exp_bits[k]});
      repeat (16) tick();
    end
    op_valid = 1'b0;
    tg_valid = 1'b0;

    // Test 3: script ownership
    do_reset();
    script_run = 1'b1;
    op_valid = 1'b1; op_bits = 8'h11;
    tg_valid = 1'b1; tg_bits = 8'h32;
    sc_valid = 1'b1; sc_bits = 8'h05;
    tick();
    check_eq("t3_acks", {29'd0, op_ack, tg_ack, sc_ack}, 32'd1);
    check_eq("t3_tx_bits", {24'd0, tx_bits}, 32'h05);
    sc_valid = 1'b0;
    repeat (5) tick();
    pulse_done();
    repeat (16) tick();
    tick();
    check_eq("t3_wait_acks", {29'd0, op_ack, tg_ack, sc_ack}, 32'd0);
    check_eq("t3_wait_busy", {31'd0, busy}, 32'd0);
    script_run = 1'b0;
    tick();
    check_eq("t3_op_first", {29'd0, op_ack, tg_ack, sc_ack}, 32'd4);
    check_eq("t3_op_bits", {24'd0, tx_bits}, 32'h11);
    op_valid = 1'b0;
    tg_valid = 1'b0;

    // Test 4: timeout
    do_reset();
    op_valid = 1'b1; op_bits = 8'h44;
    tick();
    op_valid = 1'b0;
    check_eq("t4_tx_bits", {24'd0, tx_bits}, 32'h44);
    repeat (4095) tick();
    check_eq("t4_pre_timeout", {31'd0, timeout_err}, 32'd0);
    check_eq("t4_pre_tx", {24'd0, tx_bits}, 32'h44);
    tick();
    check_eq("t4_timeout", {31'd0, timeout_err}, 32'd1);
    check_eq("t4_tx_cleared", {24'd0, tx_bits}, 32'h00);
    check_eq("t4_last_kept", {24'd0, last_byte}, 32'h00);
    repeat (16) tick();
    tg_valid = 1'b1; tg_bits = 8'h5A;
    tick();
    tg_valid = 1'b0;
    check_eq("t4_next_ack", {31'd0, tg_ack}, 32'd1);
    check_eq("t4_next_bits", {24'd0, tx_bits}, 32'h5A);
    repeat (3) tick();
    pulse_done();
    check_eq("t4_next_last", {24'd0, last_byte}, 32'h5A);
    check_eq("t4_sticky", {31'd0, timeout_err}, 32'd1);
    repeat (16) tick();

    // Test 5: asynchronous reset during SEND
    op_valid = 1'b1; op_bits = 8'h12;
    tick();
    op_valid = 1'b0;
    check_eq("t5_tx_bits", {24'd0, tx_bits}, 32'h12);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_rst_tx", {24'd0, tx_bits}, 32'h00);
    check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_rst_timeout", {31'd0, timeout_err}, 32'd0);
    check_eq("t5_rst_last", {24'd0, last_byte}, 32'h00);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_eq("t5_no_reack", {29'd0, op_ack, tg_ack, sc_ack}, 32'd0);
    check_eq("t5_idle", {31'd0, busy}, 32'd0);

    // Test 6: tx_done on the timeout cycle, spurious tx_done in GAP
    do_reset();
    op_valid = 1'b1; op_bits = 8'h66;
    tick();
    op_valid = 1'b0;
    repeat (4095) tick();
    pulse_done();
    check_eq("t6_last", {24'd0, last_byte}, 32'h66);
    check_eq("t6_no_timeout", {31'd0, timeout_err}, 32'd0);
    check_eq("t6_tx_cleared", {24'd0, tx_bits}, 32'h00);
    repeat (3) tick();
    pulse_done();
    check_eq("t6_spur_last", {24'd0, last_byte}, 32'h66);
    check_eq("t6_spur_tx", {24'd0, tx_bits}, 32'h00);
    repeat (11) tick();
    check_eq("t6_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    check_eq("t6_gap_end", {31'd0, busy}, 32'd0);
    check_eq("t6_timeout_end", {31'd0, timeout_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmit byte channel (io_dataIn_bits / io_dataIn_ready) among three requesters:
  - the operate-button encoder
  - the target-switch encoder
  - the script executor
- Latches one byte per grant, holds it on the UART input until the UART's success pulse, then enforces an inter-byte gap.
- Sits between the request sources and the UART module, in the UART clock domain.

Parameters:
GAP_CYCLES, 16, idle cycles forced after each completed byte before the next grant (>=1)
TIMEOUT_CYCLES, 4096, cycles to wait for tx_done before abandoning a byte
CNT_W, 13, counter width; must hold max(GAP_CYCLES, TIMEOUT_CYCLES)

Ports:
clock  in  1  UART clock (16x baud), sole clock
reset  in  1  asynchronous, active-low reset
script_run  in  1  1 = script executor owns the channel exclusively
op_valid  in  1  operate request pending
op_bits  in  8  operate byte
op_ack  out  1  one-cycle pulse: operate byte accepted
tg_valid  in  1  target request pending
tg_bits  in  8  target byte
tg_ack  out  1  one-cycle pulse: target byte accepted
sc_valid  in  1  script request pending
sc_bits  in  8  script byte
sc_ack  out  1  one-cycle pulse: script byte accepted
tx_bits  out  8  to UART io_dataIn_bits
tx_done  in  1  from UART io_dataIn_ready, one-cycle pulse after a byte is sent
busy  out  1  high in SEND or GAP
last_byte  out  8  last byte completed successfully (LED display)
timeout_err  out  1  sticky; set on a timeout, cleared only by reset

Behaviour:
Reset values (asynchronous, while reset=0):
- state=IDLE; tx_bits=0x00; all acks=0; busy=0; last_byte=0x00; timeout_err=0; rr_ptr=OP; counter=0.
- Asserting reset mid-SEND abandons the byte. No ack is re-issued after reset.

Output rules:
- tx_bits = 0x00 in IDLE and GAP. Host treats 0x00 as a no-op.
- All outputs are registered.

Eligible set:
- script_run=1: only sc_valid is eligible. op/tg requests wait; they are never dropped.
- script_run=0: only op_valid and tg_valid are eligible, arbitrated round-robin. rr_ptr names the preferred source. After a grant, rr_ptr points to the other source.
- If only one source is eligible and valid, it wins regardless of rr_ptr.

State IDLE:
- If any eligible valid: latch the winner's bits into tx_bits, pulse the winner's ack for exactly one cycle, load counter=0, go to SEND. All registered at the same edge.
- Requester contract: hold bits/valid until ack. On ack, drop valid or present the next byte.
- Latency: valid sampled high in IDLE -> ack and tx_bits valid on the next edge (1 cycle).

State SEND:
- Hold tx_bits. Counter increments every cycle.
- tx_done=1: last_byte<=tx_bits; tx_bits<=0x00; counter<=0; go to GAP.
- counter==TIMEOUT_CYCLES-1 with no tx_done: timeout_err<=1; tx_bits<=0x00; counter<=0; go to GAP. last_byte is unchanged.
- If tx_done and timeout coincide on the same cycle, tx_done wins and counts as success.
- A change of script_run during SEND does not abort the byte.

State GAP:
- Counter increments; on counter==GAP_CYCLES-1 go to IDLE.
- No grants and no acks during GAP.
- tx_done pulses in IDLE or GAP are ignored.

Arbitration timing:
- Eligibility is evaluated only in IDLE, using script_run sampled that cycle.

Counters:
- Saturate-free. They are reset on every state entry, so no wrap-around occurs.

Test Plan:
1. Reset low, then high. op_valid=1, op_bits=0x21 -> op_ack pulses 1 cycle later; tx_bits=0x21. tx_done pulse after 50 cycles -> last_byte=0x21; tx_bits=0x00 for 16 cycles; busy falls on the 17th cycle.
2. op_valid and tg_valid held high together, with op_bits=0x11 and tg_bits=0x32 constant, tx_done pulsed 10 cycles after each grant -> grant order op, tg, op, tg (tx_bits 0x11, 0x32, 0x11, 0x32); acks alternate.
3. script_run=1 with op_valid, tg_valid and sc_valid all high, sc_bits=0x05 -> only sc_ack fires; op/tg stay un-acked. Drop script_run to 0 -> op is granted first.
4. Grant a byte 0x44 and never pulse tx_done -> after 4096 SEND cycles: timeout_err=1, tx_bits=0x00, last_byte unchanged. After the gap, the next request is served normally; timeout_err stays 1.
5. Assert reset low during SEND of 0x12 -> tx_bits=0x00, state IDLE, timeout_err=0, last_byte=0x00 immediately, without waiting for a clock edge.
6. tx_done arrives exactly at counter=TIMEOUT_CYCLES-1 -> last_byte updated and timeout_err stays 0. A spurious tx_done during GAP has no effect.
